// File: rtl/fetch_queue_pkg.sv
// Shared cpu package: fetch FSM states, PC step and queue entry layout.
// Imported by the fetch queue and its storage FIFO.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Instruction queue storage: synchronous write, asynchronous read.
// Flush wins over push/pop and clears pointers and count.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fq_entry_t                data_i,
  input  logic                     pop_i,
  output fq_entry_t                data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload array carries no reset; count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem request, DEPTH-entry
// buffer to decode, redirect flush with drop of in-flight responses.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two >= 2");
  end

  fq_state_e     state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic          live_q;
  fq_entry_t     hold_q;

  logic [CW-1:0] count;
  fq_entry_t     head;
  fq_entry_t     shown;
  fq_entry_t     wdata;
  logic          ack;
  logic          pop;
  logic          push;
  logic          flush;
  logic          room;
  logic          issue_ok;
  logic [31:0]   pc_nxt;
  logic [31:0]   tgt_pc;

  assign ack      = imem_ack & req_q;
  assign pop      = inst_valid & inst_ready;
  assign pc_nxt   = pc_q + PC_INC;
  assign tgt_pc   = word_align(redirect_pc);
  assign room     = (count + CW'(1) - CW'(pop)) < CW'(DEPTH);
  assign issue_ok = live_q && (count < CW'(DEPTH));
  assign wdata    = '{pc: pc_q, inst: imem_data};

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      FQ_IDLE: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = tgt_pc;
        end else if (issue_ok) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FQ_WAIT;
        end
      end
      FQ_WAIT: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = tgt_pc;
          if (ack) begin
            req_d   = 1'b0;
            state_d = FQ_IDLE;
          end else begin
            state_d = FQ_DROP;
          end
        end else if (ack) begin
          push = 1'b1;
          pc_d = pc_nxt;
          if (room) begin
            addr_d = pc_nxt;
          end else begin
            req_d   = 1'b0;
            state_d = FQ_IDLE;
          end
        end
      end
      FQ_DROP: begin
        // Queue was flushed on entry; only the target can change here.
        if (redirect_valid) pc_d = tgt_pc;
        if (ack) begin
          req_d   = 1'b0;
          state_d = FQ_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = FQ_IDLE;
      end
    endcase
  end

  // live_q holds off the first request by one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FQ_IDLE;
      pc_q    <= word_align(RESET_PC);
      req_q   <= 1'b0;
      addr_q  <= '0;
      live_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      live_q  <= 1'b1;
      hold_q  <= shown;
    end
  end

  assign shown      = inst_valid ? head : hold_q;
  assign inst_valid = (count != '0);
  assign inst       = shown.inst;
  assign inst_pc    = shown.pc;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an expected-instruction scoreboard.
// Memory responder returns addr ^ 32'hFFFF_FFFF.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  exp_t        sb [$];
  logic [31:0] mpc;
  bit          drop_m;
  int          passed;
  int          failed;
  int          total;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, score pops/pushes, advance past the edge.
  task automatic tick(input bit ack_en, input bit rdy, input bit redir,
                      input logic [31:0] rpc);
    exp_t e;
    bit   ack;
    bit   acc;
    chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    ack            = ack_en && (imem_req === 1'b1);
    imem_ack       = ack;
    imem_data      = imem_addr ^ 32'hFFFF_FFFF;
    if (!redir && rdy && sb.size() != 0) begin
      e = sb.pop_front();
      chk("inst_pc", inst_pc, e.pc);
      chk("inst", inst, e.ins);
    end
    acc = ack && !redir && !drop_m;
    if (acc) begin
      chk("imem_addr", imem_addr, mpc);
      sb.push_back('{pc: mpc, ins: mpc ^ 32'hFFFF_FFFF});
      mpc = mpc + 32'd4;
    end
    if (ack && drop_m) drop_m = 1'b0;
    if (redir) begin
      sb.delete();
      mpc = rpc & ~32'h3;
    end
    @(posedge clk);
    #1;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input bit late_ack);
    imem_ack       = late_ack;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    rst            = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    sb.delete();
    mpc    = RESET_PC;
    drop_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_edge1_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_edge2_req", 32'(imem_req), 32'd1);
    chk("rel_edge2_addr", imem_addr, RESET_PC);
    chk("rel_no_late_ack", 32'(inst_valid), 32'd0);
    imem_ack = 1'b0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    mpc    = RESET_PC;
    drop_m = 1'b0;
    #2;

    // Streaming with decode always ready
    do_reset(1'b0);
    repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);

    // Fill to capacity with decode stalled, then drain
    do_reset(1'b0);
    repeat (6) tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_req_low", 32'(imem_req), 32'd0);
    chk("full_head_pc", inst_pc, 32'h0);
    repeat (8) tick(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while waiting on 0x8; late ack is dropped
    do_reset(1'b0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h100);
    drop_m = 1'b1;
    chk("drop_req_held", 32'(imem_req), 32'd1);
    chk("drop_addr_held", imem_addr, 32'h8);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("drop_addr_held2", imem_addr, 32'h8);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_done_req", 32'(imem_req), 32'd0);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with ack and pop
    chk("pre_rd2_valid", 32'(inst_valid), 32'd1);
    chk("pre_rd2_req", 32'(imem_req), 32'd1);
    tick(1'b1, 1'b1, 1'b1, 32'h200);
    chk("rd2_flushed", 32'(inst_valid), 32'd0);
    chk("rd2_req_idle", 32'(imem_req), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rd2_next_req", 32'(imem_req), 32'd1);
    chk("rd2_next_addr", imem_addr, 32'h200);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap; low redirect bits ignored
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset with a request outstanding and ack asserted
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    do_reset(1'b1);
    repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port imem_req, output, 1 bit: instruction memory request, registered.
REQ-006 Port imem_addr, output, 32 bits: fetch address, registered, word-aligned.
REQ-007 Port imem_ack, input, 1 bit: one-cycle completion pulse; imem_data is valid in the same cycle.
REQ-008 Port imem_data, input, 32 bits: fetched instruction word.
REQ-009 Port redirect_valid, input, 1 bit: branch/jump redirect.
REQ-010 Port redirect_pc, input, 32 bits: redirect target; bits [1:0] SHALL be ignored and treated as zero.
REQ-011 Port inst_valid, output, 1 bit: the queue head is valid.
REQ-012 Port inst, output, 32 bits: head instruction, fed to the decode pipeline register.
REQ-013 Port inst_pc, output, 32 bits: address of the head instruction.
REQ-014 Port inst_ready, input, 1 bit: decode accepts the head instruction.

Function
REQ-015 The FSM SHALL have three states: IDLE (nothing outstanding), WAIT (request outstanding), DROP (outstanding request whose result is discarded).
REQ-016 In IDLE, with no redirect and (count + 0) < DEPTH, the block SHALL assert imem_req with imem_addr = pc on the next edge and enter WAIT.
REQ-017 In WAIT and DROP, imem_req and imem_addr SHALL stay stable until an edge at which imem_ack = 1.
REQ-018 imem_ack SHALL be ignored while imem_req = 0.
REQ-019 WAIT with ack and no redirect: push {pc, imem_data} and set pc = pc + 4 (32-bit wrap).
REQ-020 If the queue still has a free slot after that push (accounting for a same-cycle pop), the block SHALL issue the next request at the same edge and remain in WAIT; otherwise it SHALL drop imem_req and go to IDLE.
REQ-021 The request issue rule SHALL guarantee that a push never occurs into a full queue; the number of outstanding requests is at most 1.
REQ-022 A pop SHALL occur when inst_valid and inst_ready are both 1; push and pop in the same cycle SHALL leave count unchanged.
REQ-023 inst_valid SHALL equal (count != 0); inst and inst_pc SHALL show the head entry directly from storage, adding no cycle of latency.
REQ-024 When inst_valid = 0, inst and inst_pc SHALL hold their last values, and inst_valid alone qualifies them.
REQ-025 Redirect has priority over everything: at that edge the queue SHALL be flushed (count = 0, pointers reset), any same-cycle pop or push SHALL be discarded, and pc SHALL be set to redirect_pc.
REQ-026 Redirect in IDLE: go to IDLE with the new pc; the first request SHALL issue on the following edge.
REQ-027 Redirect in WAIT without ack: go to DROP, keeping imem_req and the old imem_addr held.
REQ-028 Redirect with ack in the same cycle: the ack data SHALL be discarded, and the block SHALL go to IDLE.
REQ-029 In DROP, ack SHALL be discarded with the state going to IDLE; a further redirect while in DROP SHALL only update pc.
REQ-030 Minimum latency SHALL be: imem_ack sampled at edge N gives inst_valid = 1 after edge N when the queue was empty.

Reset
REQ-031 While rst = 0, and asynchronously, the block SHALL set: pc = RESET_PC, state = IDLE, count = 0, pointers = 0, imem_req = 0, imem_addr = 0, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-032 Reset mid-request SHALL abandon the outstanding request without tracking a late ack.
REQ-033 The first request after reset release SHALL issue on the second rising edge after rst deasserts.

Structure
REQ-034 The state encoding (IDLE, WAIT, DROP) and the constant for the 4-byte PC increment SHALL live in the shared cpu package.
REQ-035 One sub-module, fq_fifo, SHALL hold the storage: a synchronous-write, asynchronous-read FIFO of DEPTH x 64 bits with a flush input and a count output.
REQ-036 All other logic SHALL be in fetch_queue.

Verification
REQ-037 Reset, then ack every cycle with imem_data = addr ^ 32'hFFFF_FFFF and inst_ready = 1 -> inst_pc sequence 0, 4, 8, 12, one instruction per cycle after the first.
REQ-038 inst_ready = 0 with immediate acks -> exactly 4 entries (0x0 to 0xC) are queued and imem_req goes low; inst_ready = 1 -> the entries drain in order and fetch resumes at 0x10.
REQ-039 Redirect to 0x100 while in WAIT at 0x8, with ack 3 cycles later -> the 0x8 data never appears and the next inst_pc is 0x100.
REQ-040 Redirect to 0x200 in the same cycle as an ack and a pop -> the queue is empty next cycle, the next request is 0x200, and there is no stale output.
REQ-041 pc = 0xFFFF_FFFC with an ack -> the next imem_addr is 0x0000_0000.
REQ-042 Assert rst low while imem_req = 1 with the ack pending -> all outputs are zero immediately, and after release the first imem_addr is RESET_PC.
